// File: rtl/multicycle_control.sv
// multicycle_control: control FSM for the multi-cycle MIPS-subset datapath.
// Sequences each instruction through fetch/decode/execute/memory/writeback,
// drives the shared-memory datapath muxes and enables, and handshakes with a
// variable-latency memory. A per-access wait counter faults a stuck memory.
//
// Ports:
//   clock, resetN               clock (rising edge), synchronous active-low reset
//   opcode, funct               instruction fields from the instruction register
//   zero                        ALU zero flag (branch decision)
//   memReady                    memory completes the current access this cycle
//   pcEn, pcSrc                 PC enable and PC source select
//   iOrD, memRead, memWrite     memory address select and requests
//   irWrite                     instruction register load
//   regDst, memToReg, regWrite  register-file write controls
//   aluSrcA, aluSrcB, aluControl ALU operand selects and operation
//   state, retired              debug state, one-cycle completion pulse
//   fault, faultCause           sticky fault flag and its cause
//
// state  | meaning
// FETCH  | read instruction at PC, PC+4 -> PC on memReady
// DECODE | precompute branch target, dispatch on opcode
// MEMADR | compute load/store address
// MEMRD  | load data read, waits on memReady
// MEMWB  | load data -> rt
// MEMWR  | store write, waits on memReady
// EXEC   | R-type ALU operation
// ALUWB  | ALU result -> rd
// BRANCH | compare, conditionally take branch target
// ADDIEX | rs + immediate
// ADDIWB | ALU result -> rt
// JUMP   | jump target -> PC
// FAULT  | terminal until reset
module multicycle_control #(
   parameter int ALU_CTRL_W  = 5,
   parameter bit ENABLE_BNE  = 1'b1,
   parameter int MEM_TIMEOUT = 16,
   parameter int TCNT_W      = 8
) (
   input  logic                  clock,
   input  logic                  resetN,
   input  logic [5:0]            opcode,
   input  logic [5:0]            funct,
   input  logic                  zero,
   input  logic                  memReady,
   output logic                  pcEn,
   output logic [1:0]            pcSrc,
   output logic                  iOrD,
   output logic                  memRead,
   output logic                  memWrite,
   output logic                  irWrite,
   output logic                  regDst,
   output logic                  memToReg,
   output logic                  regWrite,
   output logic                  aluSrcA,
   output logic [1:0]            aluSrcB,
   output logic [ALU_CTRL_W-1:0] aluControl,
   output logic [3:0]            state,
   output logic                  retired,
   output logic                  fault,
   output logic [1:0]            faultCause
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11,
      S_FAULT  = 4'd15
   } state_e;

   localparam logic [ALU_CTRL_W-1:0] ALU_ADD = ALU_CTRL_W'(0);
   localparam logic [ALU_CTRL_W-1:0] ALU_SUB = ALU_CTRL_W'(1);
   localparam logic [ALU_CTRL_W-1:0] ALU_AND = ALU_CTRL_W'(2);
   localparam logic [ALU_CTRL_W-1:0] ALU_OR  = ALU_CTRL_W'(3);
   localparam logic [ALU_CTRL_W-1:0] ALU_SLT = ALU_CTRL_W'(4);

   localparam int                TMO_LAST_I = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
   localparam logic [TCNT_W-1:0] TMO_LAST   = TCNT_W'(TMO_LAST_I);

   state_e            state_q, state_d;
   logic [TCNT_W-1:0] wcnt_q, wcnt_d;
   logic [1:0]        cause_q, cause_d;

   logic                  pc_en_c, i_or_d_c, mem_rd_c, mem_wr_c, ir_wr_c;
   logic                  reg_dst_c, mem_to_reg_c, reg_wr_c, src_a_c, ret_c;
   logic [1:0]            pc_src_c, src_b_c;
   logic [ALU_CTRL_W-1:0] alu_c;
   logic                  mem_state, tmo_hit;

   assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
   // memReady takes priority over an expiring timeout, so tmo_hit excludes it.
   assign tmo_hit   = (MEM_TIMEOUT != 0) && mem_state && !memReady && (wcnt_q == TMO_LAST);
   assign wcnt_d    = (mem_state && !memReady) ? wcnt_q + 1'b1 : '0;

   always_ff @(posedge clock) begin
      if (!resetN) begin
         state_q <= S_FETCH;
         wcnt_q  <= '0;
         cause_q <= 2'd0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         cause_q <= cause_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cause_d      = cause_q;
      pc_en_c      = 1'b0;
      pc_src_c     = 2'd0;
      i_or_d_c     = 1'b0;
      mem_rd_c     = 1'b0;
      mem_wr_c     = 1'b0;
      ir_wr_c      = 1'b0;
      reg_dst_c    = 1'b0;
      mem_to_reg_c = 1'b0;
      reg_wr_c     = 1'b0;
      src_a_c      = 1'b0;
      src_b_c      = 2'd0;
      alu_c        = ALU_ADD;
      ret_c        = 1'b0;
      unique case (state_q)
         S_FETCH: begin
            mem_rd_c = 1'b1;
            src_b_c  = 2'd1;
            ir_wr_c  = memReady;
            pc_en_c  = memReady;
            if (memReady)     state_d = S_DECODE;
            else if (tmo_hit) begin state_d = S_FAULT; cause_d = 2'd3; end
         end
         S_DECODE: begin
            src_b_c = 2'd3;
            unique case (opcode)
               6'h23, 6'h2B: state_d = S_MEMADR;
               6'h00:        state_d = S_EXEC;
               6'h04:        state_d = S_BRANCH;
               6'h05: begin
                  if (ENABLE_BNE) state_d = S_BRANCH;
                  else begin state_d = S_FAULT; cause_d = 2'd1; end
               end
               6'h08:        state_d = S_ADDIEX;
               6'h02:        state_d = S_JUMP;
               default: begin state_d = S_FAULT; cause_d = 2'd1; end
            endcase
         end
         S_MEMADR: begin
            src_a_c = 1'b1;
            src_b_c = 2'd2;
            state_d = (opcode == 6'h2B) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            i_or_d_c = 1'b1;
            mem_rd_c = 1'b1;
            if (memReady)     state_d = S_MEMWB;
            else if (tmo_hit) begin state_d = S_FAULT; cause_d = 2'd3; end
         end
         S_MEMWB: begin
            mem_to_reg_c = 1'b1;
            reg_wr_c     = 1'b1;
            ret_c        = 1'b1;
            state_d      = S_FETCH;
         end
         S_MEMWR: begin
            i_or_d_c = 1'b1;
            mem_wr_c = 1'b1;
            ret_c    = memReady;
            if (memReady)     state_d = S_FETCH;
            else if (tmo_hit) begin state_d = S_FAULT; cause_d = 2'd3; end
         end
         S_EXEC: begin
            src_a_c = 1'b1;
            state_d = S_ALUWB;
            unique case (funct)
               6'h20:   alu_c = ALU_ADD;
               6'h22:   alu_c = ALU_SUB;
               6'h24:   alu_c = ALU_AND;
               6'h25:   alu_c = ALU_OR;
               6'h2A:   alu_c = ALU_SLT;
               default: begin state_d = S_FAULT; cause_d = 2'd2; end
            endcase
         end
         S_ALUWB: begin
            reg_dst_c = 1'b1;
            reg_wr_c  = 1'b1;
            ret_c     = 1'b1;
            state_d   = S_FETCH;
         end
         S_BRANCH: begin
            src_a_c  = 1'b1;
            alu_c    = ALU_SUB;
            pc_src_c = 2'd1;
            ret_c    = 1'b1;
            pc_en_c  = (opcode == 6'h05) ? ~zero : zero;
            state_d  = S_FETCH;
         end
         S_ADDIEX: begin
            src_a_c = 1'b1;
            src_b_c = 2'd2;
            state_d = S_ADDIWB;
         end
         S_ADDIWB: begin
            reg_wr_c = 1'b1;
            ret_c    = 1'b1;
            state_d  = S_FETCH;
         end
         S_JUMP: begin
            pc_src_c = 2'd2;
            pc_en_c  = 1'b1;
            ret_c    = 1'b1;
            state_d  = S_FETCH;
         end
         S_FAULT: state_d = S_FAULT;
         default: state_d = S_FETCH;
      endcase
   end

   // Every output is held low while reset is asserted, abandoning any access.
   assign pcEn       = resetN & pc_en_c;
   assign pcSrc      = resetN ? pc_src_c : 2'd0;
   assign iOrD       = resetN & i_or_d_c;
   assign memRead    = resetN & mem_rd_c;
   assign memWrite   = resetN & mem_wr_c;
   assign irWrite    = resetN & ir_wr_c;
   assign regDst     = resetN & reg_dst_c;
   assign memToReg   = resetN & mem_to_reg_c;
   assign regWrite   = resetN & reg_wr_c;
   assign aluSrcA    = resetN & src_a_c;
   assign aluSrcB    = resetN ? src_b_c : 2'd0;
   assign aluControl = resetN ? alu_c : '0;
   assign state      = resetN ? state_q : 4'd0;
   assign retired    = resetN & ret_c;
   assign fault      = resetN & (state_q == S_FAULT);
   assign faultCause = resetN ? cause_q : 2'd0;

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control. Two instances share all inputs: u_dut0 has
// bne enabled, u_dut1 has it disabled; both use a 4-cycle memory timeout.
// Each stimulus cycle pushes hand-computed expected output vectors into a
// queue; a monitor on the falling edge pops and compares them.
module tb_multicycle_control;

   logic       clock, resetN, zero, memReady;
   logic [5:0] opcode, funct;

   logic       pcEn0, iOrD0, memRead0, memWrite0, irWrite0, regDst0, memToReg0;
   logic       regWrite0, aluSrcA0, retired0, fault0;
   logic [1:0] pcSrc0, aluSrcB0, faultCause0;
   logic [4:0] aluControl0;
   logic [3:0] state0;

   logic       pcEn1, iOrD1, memRead1, memWrite1, irWrite1, regDst1, memToReg1;
   logic       regWrite1, aluSrcA1, retired1, fault1;
   logic [1:0] pcSrc1, aluSrcB1, faultCause1;
   logic [4:0] aluControl1;
   logic [3:0] state1;

   multicycle_control #(.ALU_CTRL_W(5), .ENABLE_BNE(1'b1), .MEM_TIMEOUT(4), .TCNT_W(8)) u_dut0 (
      .clock(clock), .resetN(resetN), .opcode(opcode), .funct(funct), .zero(zero),
      .memReady(memReady), .pcEn(pcEn0), .pcSrc(pcSrc0), .iOrD(iOrD0),
      .memRead(memRead0), .memWrite(memWrite0), .irWrite(irWrite0), .regDst(regDst0),
      .memToReg(memToReg0), .regWrite(regWrite0), .aluSrcA(aluSrcA0), .aluSrcB(aluSrcB0),
      .aluControl(aluControl0), .state(state0), .retired(retired0), .fault(fault0),
      .faultCause(faultCause0));

   multicycle_control #(.ALU_CTRL_W(5), .ENABLE_BNE(1'b0), .MEM_TIMEOUT(4), .TCNT_W(8)) u_dut1 (
      .clock(clock), .resetN(resetN), .opcode(opcode), .funct(funct), .zero(zero),
      .memReady(memReady), .pcEn(pcEn1), .pcSrc(pcSrc1), .iOrD(iOrD1),
      .memRead(memRead1), .memWrite(memWrite1), .irWrite(irWrite1), .regDst(regDst1),
      .memToReg(memToReg1), .regWrite(regWrite1), .aluSrcA(aluSrcA1), .aluSrcB(aluSrcB1),
      .aluControl(aluControl1), .state(state1), .retired(retired1), .fault(fault1),
      .faultCause(faultCause1));

   // {state, pcEn, pcSrc, iOrD, memRead, memWrite, irWrite, regDst, memToReg,
   //  regWrite, aluSrcA, aluSrcB, aluControl, retired, fault, faultCause}
   logic [25:0] act0, act1;
   assign act0 = {state0, pcEn0, pcSrc0, iOrD0, memRead0, memWrite0, irWrite0, regDst0,
                  memToReg0, regWrite0, aluSrcA0, aluSrcB0, aluControl0, retired0, fault0,
                  faultCause0};
   assign act1 = {state1, pcEn1, pcSrc1, iOrD1, memRead1, memWrite1, irWrite1, regDst1,
                  memToReg1, regWrite1, aluSrcA1, aluSrcB1, aluControl1, retired1, fault1,
                  faultCause1};

   typedef struct {
      logic [25:0] v0;
      logic [25:0] v1;
      string       tag;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2B, OP_BEQ = 6'h04;
   localparam logic [5:0] OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_J = 6'h02, OP_BAD = 6'h3F;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [25:0] mkv(input logic [3:0] st, input logic pe, input logic [1:0] ps,
                                       input logic iod, rd, wr, irw, rdst, m2r, rw, sa,
                                       input logic [1:0] sb, input logic [4:0] alu,
                                       input logic ret, flt, input logic [1:0] fc);
      return {st, pe, ps, iod, rd, wr, irw, rdst, m2r, rw, sa, sb, alu, ret, flt, fc};
   endfunction

   task automatic drv(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                      input logic z, input logic mr);
      @(posedge clock);
      #1;
      resetN   = rst;
      opcode   = op;
      funct    = fn;
      zero     = z;
      memReady = mr;
   endtask

   // Expected outputs for the cycle just driven; both instances expected equal.
   task automatic ex(input string tag, input logic [3:0] st, input logic pe, input logic [1:0] ps,
                     input logic iod, rd, wr, irw, rdst, m2r, rw, sa,
                     input logic [1:0] sb, input logic [4:0] alu,
                     input logic ret, flt, input logic [1:0] fc);
      exp_t e;
      e.tag = tag;
      e.v0  = mkv(st, pe, ps, iod, rd, wr, irw, rdst, m2r, rw, sa, sb, alu, ret, flt, fc);
      e.v1  = e.v0;
      q.push_back(e);
   endtask

   // Override the u_dut1 expectation of the last pushed cycle with a FAULT state.
   task automatic ex_b_fault(input logic [1:0] fc);
      exp_t e;
      e    = q.pop_back();
      e.v1 = mkv(4'd15, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 5'd0, 0, 1, fc);
      q.push_back(e);
   endtask

   always @(negedge clock) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         n_cmp++;
         if (act0 !== e.v0) begin
            n_err++;
            $display("FAIL %s dut0: got %b required %b", e.tag, act0, e.v0);
         end
         n_cmp++;
         if (act1 !== e.v1) begin
            n_err++;
            $display("FAIL %s dut1: got %b required %b", e.tag, act1, e.v1);
         end
      end
   end

   initial begin
      resetN = 1'b0; opcode = 6'h00; funct = 6'h00; zero = 1'b0; memReady = 1'b1;

      // reset held two cycles: every output forced low
      drv(0, OP_LW, 6'h00, 0, 1); ex("rst0", 0, 0,0, 0,0,0,0, 0,0,0, 0,0,0, 0,0,0);
      drv(0, OP_LW, 6'h00, 0, 1); ex("rst1", 0, 0,0, 0,0,0,0, 0,0,0, 0,0,0, 0,0,0);

      // lw, memReady tied high: 5 cycles
      drv(1, OP_LW, 6'h00, 0, 1); ex("lw.fetch", 0, 1,0, 0,1,0,1, 0,0,0, 0,1,0, 0,0,0);
      drv(1, OP_LW, 6'h00, 0, 1); ex("lw.dec",   1, 0,0, 0,0,0,0, 0,0,0, 0,3,0, 0,0,0);
      drv(1, OP_LW, 6'h00, 0, 1); ex("lw.adr",   2, 0,0, 0,0,0,0, 0,0,0, 1,2,0, 0,0,0);
      drv(1, OP_LW, 6'h00, 0, 1); ex("lw.rd",    3, 0,0, 1,1,0,0, 0,0,0, 0,0,0, 0,0,0);
      drv(1, OP_LW, 6'h00, 0, 1); ex("lw.wb",    4, 0,0, 0,0,0,0, 0,1,1, 0,0,0, 1,0,0);

      // R-type sub, then slt
      drv(1, OP_R, 6'h22, 0, 1); ex("sub.fetch", 0, 1,0, 0,1,0,1, 0,0,0, 0,1,0, 0,0,0);
      drv(1, OP_R, 6'h22, 0, 1); ex("sub.dec",   1, 0,0, 0,0,0,0, 0,0,0, 0,3,0, 0,0,0);
      drv(1, OP_R, 6'h22, 0, 1); ex("sub.exec",  6, 0,0, 0,0,0,0, 0,0,0, 1,0,1, 0,0,0);
      drv(1, OP_R, 6'h22, 0, 1); ex("sub.wb",    7, 0,0, 0,0,0,0, 1,0,1, 0,0,0, 1,0,0);
      drv(1, OP_R, 6'h2A, 0, 1); ex("slt.fetch", 0, 1,0, 0,1,0,1, 0,0,0, 0,1,0, 0,0,0);
      drv(1, OP_R, 6'h2A, 0, 1); ex("slt.dec",   1, 0,0, 0,0,0,0, 0,0,0, 0,3,0, 0,0,0);
      drv(1, OP_R, 6'h2A, 0, 1); ex("slt.exec",  6, 0,0, 0,0,0,0, 0,0,0, 1,0,4, 0,0,0);
      drv(1, OP_R, 6'h2A, 0, 1); ex("slt.wb",    7, 0,0, 0,0,0,0, 1,0,1, 0,0,0, 1,0,0);

      // beq not taken, then taken
      drv(1, OP_BEQ, 6'h00, 0, 1); ex("beq0.fetch", 0, 1,0, 0,1,0,1, 0,0,0, 0,1,0, 0,0,0);
      drv(1, OP_BEQ, 6'h00, 0, 1); ex("beq0.dec",   1, 0,0, 0,0,0,0, 0,0,0, 0,3,0, 0,0,0);
      drv(1, OP_BEQ, 6'h00, 0, 1); ex("beq0.br",    8, 0,1, 0,0,0,0, 0,0,0, 1,0,1, 1,0,0);
      drv(1, OP_BEQ, 6'h00, 1, 1); ex("beq1.fetch", 0, 1,0, 0,1,0,1, 0,0,0, 0,1,0, 0,0,0);
      drv(1, OP_BEQ, 6'h00, 1, 1); ex("beq1.dec",   1, 0,0, 0,0,0,0, 0,0,0, 0,3,0, 0,0,0);
      drv(1, OP_BEQ, 6'h00, 1, 1); ex("beq1.br",    8, 1,1, 0,0,0,0, 0,0,0, 1,0,1, 1,0,0);

      // addi, j
      drv(1, OP_ADDI, 6'h00, 0, 1); ex("addi.fetch", 0, 1,0, 0,1,0,1, 0,0,0, 0,1,0, 0,0,0);
      drv(1, OP_ADDI, 6'h00, 0, 1); ex("addi.dec",   1, 0,0, 0,0,0,0, 0,0,0, 0,3,0, 0,0,0);
      drv(1, OP_ADDI, 6'h00, 0, 1); ex("addi.ex",    9, 0,0, 0,0,0,0, 0,0,0, 1,2,0, 0,0,0);
      drv(1, OP_ADDI, 6'h00, 0, 1); ex("addi.wb",   10, 0,0, 0,0,0,0, 0,0,1, 0,0,0, 1,0,0);
      drv(1, OP_J, 6'h00, 0, 1);    ex("j.fetch",    0, 1,0, 0,1,0,1, 0,0,0, 0,1,0, 0,0,0);
      drv(1, OP_J, 6'h00, 0, 1);    ex("j.dec",      1, 0,0, 0,0,0,0, 0,0,0, 0,3,0, 0,0,0);
      drv(1, OP_J, 6'h00, 0, 1);    ex("j.jump",    11, 1,2, 0,0,0,0, 0,0,0, 0,0,0, 1,0,0);

      // sw with one fetch wait and one write wait
      drv(1, OP_SW, 6'h00, 0, 0); ex("sw.fwait",  0, 0,0, 0,1,0,0, 0,0,0, 0,1,0, 0,0,0);
      drv(1, OP_SW, 6'h00, 0, 1); ex("sw.fetch",  0, 1,0, 0,1,0,1, 0,0,0, 0,1,0, 0,0,0);
      drv(1, OP_SW, 6'h00, 0, 1); ex("sw.dec",    1, 0,0, 0,0,0,0, 0,0,0, 0,3,0, 0,0,0);
      drv(1, OP_SW, 6'h00, 0, 1); ex("sw.adr",    2, 0,0, 0,0,0,0, 0,0,0, 1,2,0, 0,0,0);
      drv(1, OP_SW, 6'h00, 0, 0); ex("sw.wwait",  5, 0,0, 1,0,1,0, 0,0,0, 0,0,0, 0,0,0);
      drv(1, OP_SW, 6'h00, 0, 1); ex("sw.wr",     5, 0,0, 1,0,1,0, 0,0,0, 0,0,0, 1,0,0);

      // lw: memReady arrives on the 4th MEMRD cycle, beating the timeout
      drv(1, OP_LW, 6'h00, 0, 1); ex("lwr.fetch", 0, 1,0, 0,1,0,1, 0,0,0, 0,1,0, 0,0,0);
      drv(1, OP_LW, 6'h00, 0, 1); ex("lwr.dec",   1, 0,0, 0,0,0,0, 0,0,0, 0,3,0, 0,0,0);
      drv(1, OP_LW, 6'h00, 0, 1); ex("lwr.adr",   2, 0,0, 0,0,0,0, 0,0,0, 1,2,0, 0,0,0);
      for (int i = 0; i < 3; i++) begin
         drv(1, OP_LW, 6'h00, 0, 0); ex("lwr.wait", 3, 0,0, 1,1,0,0, 0,0,0, 0,0,0, 0,0,0);
      end
      drv(1, OP_LW, 6'h00, 0, 1); ex("lwr.rd4",   3, 0,0, 1,1,0,0, 0,0,0, 0,0,0, 0,0,0);
      drv(1, OP_LW, 6'h00, 0, 1); ex("lwr.wb",    4, 0,0, 0,0,0,0, 0,1,1, 0,0,0, 1,0,0);

      // bne: taken on dut0 (zero=0), illegal opcode on dut1
      drv(1, OP_BNE, 6'h00, 0, 1); ex("bne.fetch", 0, 1,0, 0,1,0,1, 0,0,0, 0,1,0, 0,0,0);
      drv(1, OP_BNE, 6'h00, 0, 1); ex("bne.dec",   1, 0,0, 0,0,0,0, 0,0,0, 0,3,0, 0,0,0);
      drv(1, OP_BNE, 6'h00, 0, 1); ex("bne.br",    8, 1,1, 0,0,0,0, 0,0,0, 1,0,1, 1,0,0);
      ex_b_fault(2'd1);
      drv(0, OP_R, 6'h00, 0, 1);   ex("bne.rst",   0, 0,0, 0,0,0,0, 0,0,0, 0,0,0, 0,0,0);

      // illegal funct: fault cause 2, no writeback
      drv(1, OP_R, 6'h3F, 0, 1); ex("badf.fetch", 0, 1,0, 0,1,0,1, 0,0,0, 0,1,0, 0,0,0);
      drv(1, OP_R, 6'h3F, 0, 1); ex("badf.dec",   1, 0,0, 0,0,0,0, 0,0,0, 0,3,0, 0,0,0);
      drv(1, OP_R, 6'h3F, 0, 1); ex("badf.exec",  6, 0,0, 0,0,0,0, 0,0,0, 1,0,0, 0,0,0);
      drv(1, OP_R, 6'h3F, 0, 1); ex("badf.flt",  15, 0,0, 0,0,0,0, 0,0,0, 0,0,0, 0,1,2);
      drv(1, OP_R, 6'h20, 0, 1); ex("badf.hold", 15, 0,0, 0,0,0,0, 0,0,0, 0,0,0, 0,1,2);
      drv(0, OP_LW, 6'h00, 0, 1); ex("badf.rst",  0, 0,0, 0,0,0,0, 0,0,0, 0,0,0, 0,0,0);

      // memory timeout: four MEMRD cycles without memReady, then fault cause 3
      drv(1, OP_LW, 6'h00, 0, 1); ex("tmo.fetch", 0, 1,0, 0,1,0,1, 0,0,0, 0,1,0, 0,0,0);
      drv(1, OP_LW, 6'h00, 0, 1); ex("tmo.dec",   1, 0,0, 0,0,0,0, 0,0,0, 0,3,0, 0,0,0);
      drv(1, OP_LW, 6'h00, 0, 1); ex("tmo.adr",   2, 0,0, 0,0,0,0, 0,0,0, 1,2,0, 0,0,0);
      for (int i = 0; i < 4; i++) begin
         drv(1, OP_LW, 6'h00, 0, 0); ex("tmo.wait", 3, 0,0, 1,1,0,0, 0,0,0, 0,0,0, 0,0,0);
      end
      drv(1, OP_LW, 6'h00, 0, 0); ex("tmo.flt",  15, 0,0, 0,0,0,0, 0,0,0, 0,0,0, 0,1,3);
      drv(1, OP_LW, 6'h00, 0, 1); ex("tmo.hold", 15, 0,0, 0,0,0,0, 0,0,0, 0,0,0, 0,1,3);
      drv(0, OP_SW, 6'h00, 0, 1); ex("tmo.rst",   0, 0,0, 0,0,0,0, 0,0,0, 0,0,0, 0,0,0);

      // reset during a MEMWR wait abandons the store; fault flag stays cleared
      drv(1, OP_SW, 6'h00, 0, 1); ex("swr.fetch", 0, 1,0, 0,1,0,1, 0,0,0, 0,1,0, 0,0,0);
      drv(1, OP_SW, 6'h00, 0, 1); ex("swr.dec",   1, 0,0, 0,0,0,0, 0,0,0, 0,3,0, 0,0,0);
      drv(1, OP_SW, 6'h00, 0, 1); ex("swr.adr",   2, 0,0, 0,0,0,0, 0,0,0, 1,2,0, 0,0,0);
      drv(1, OP_SW, 6'h00, 0, 0); ex("swr.wait",  5, 0,0, 1,0,1,0, 0,0,0, 0,0,0, 0,0,0);
      drv(0, OP_SW, 6'h00, 0, 0); ex("swr.rst",   0, 0,0, 0,0,0,0, 0,0,0, 0,0,0, 0,0,0);
      drv(1, OP_BAD, 6'h00, 0, 1); ex("swr.after", 0, 1,0, 0,1,0,1, 0,0,0, 0,1,0, 0,0,0);

      // illegal opcode: fault cause 1 on both instances
      drv(1, OP_BAD, 6'h00, 0, 1); ex("bado.dec",  1, 0,0, 0,0,0,0, 0,0,0, 0,3,0, 0,0,0);
      drv(1, OP_BAD, 6'h00, 0, 1); ex("bado.flt", 15, 0,0, 0,0,0,0, 0,0,0, 0,0,0, 0,1,1);
      drv(0, OP_BAD, 6'h00, 0, 1); ex("bado.rst",  0, 0,0, 0,0,0,0, 0,0,0, 0,0,0, 0,0,0);
      drv(1, OP_J, 6'h00, 0, 1);   ex("end.fetch", 0, 1,0, 0,1,0,1, 0,0,0, 0,1,0, 0,0,0);

      repeat (2) @(posedge clock);
      n_cmp++;
      if (q.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d expected entries left, required 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Control unit for the multi-cycle generation of the MIPS-subset processor. It replaces the single-cycle combinational decoder.
- It sequences each instruction through an FSM: fetch, decode, execute, memory, writeback. It drives the shared-memory datapath muxes and enables, and handshakes with a variable-latency memory.
- It adds a parametrised ALU select width, optional bne support, a memory-wait timeout, and sticky fault reporting.

Parameters:
- ALU_CTRL_W, 5, width of the aluControl select. Codes: ADD=0, SUB=1, AND=2, OR=3, SLT=4, zero-extended.
- ENABLE_BNE, 1, 1 = opcode 0x05 (bne) is legal; 0 = it faults as illegal.
- MEM_TIMEOUT, 16, maximum wait cycles per memory access before a fault. 0 disables the timeout.
- TCNT_W, 8, width of the wait counter. Must satisfy MEM_TIMEOUT < 2^TCNT_W.

Ports:
- clock  in  1  sole clock, rising edge
- resetN  in  1  synchronous, active-low reset
- opcode  in  6  instr[31:26] from the instruction register
- funct  in  6  instr[5:0]
- zero  in  1  ALU zero flag
- memReady  in  1  memory has completed the current access this cycle
- pcEn  out  1  PC register enable
- pcSrc  out  2  0=ALUResult, 1=ALUOut register, 2=jump target
- iOrD  out  1  0=PC addresses memory, 1=ALUOut
- memRead  out  1  memory read request
- memWrite  out  1  memory write request
- irWrite  out  1  instruction register load
- regDst  out  1  0=rt, 1=rd
- memToReg  out  1  0=ALUOut, 1=data register
- regWrite  out  1  register file write enable
- aluSrcA  out  1  0=PC, 1=register A
- aluSrcB  out  2  0=register B, 1=constant 4, 2=SignImm, 3=SignImm<<2
- aluControl  out  ALU_CTRL_W  ALU operation select
- state  out  4  current state encoding, for debug
- retired  out  1  one-cycle pulse when an instruction completes
- fault  out  1  sticky fault flag
- faultCause  out  2  0=none, 1=illegal opcode, 2=illegal funct, 3=memory timeout

Behaviour:
- Reset: while resetN=0 at a rising edge, state<=FETCH(0), wait counter<=0, fault<=0, faultCause<=0.
  - All outputs are combinational from state, so after reset they take the FETCH values. The first FETCH request is issued in the cycle after resetN rises.
  - Outputs are forced to 0 in any cycle where resetN=0.
  - Reset mid-access abandons the access with no writes.
- States (4-bit encoding): FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, FAULT=15.
- All outputs not listed for a state are 0.
- FETCH: iOrD=0, memRead=1, aluSrcA=0, aluSrcB=1, ADD, pcSrc=0.
  - irWrite=memReady and pcEn=memReady (Mealy).
  - Move to DECODE when memReady=1; otherwise stay.
- DECODE: aluSrcA=0, aluSrcB=3, ADD (precomputes the branch target). Next state by opcode:
  - 0x23 or 0x2B -> MEMADR
  - 0x00 -> EXEC
  - 0x04 -> BRANCH; 0x05 -> BRANCH if ENABLE_BNE, otherwise illegal
  - 0x08 -> ADDIEX
  - 0x02 -> JUMP
  - any other opcode -> FAULT with cause 1
- MEMADR: aluSrcA=1, aluSrcB=2, ADD. Next state is MEMRD for 0x23, MEMWR for 0x2B.
- MEMRD: iOrD=1, memRead=1. Move to MEMWB on memReady.
- MEMWB: regDst=0, memToReg=1, regWrite=1, retired=1. Next state FETCH.
- MEMWR: iOrD=1, memWrite=1. On memReady: retired=1 and next state FETCH.
- EXEC: aluSrcA=1, aluSrcB=0. aluControl by funct:
  - 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT
  - any other funct -> FAULT with cause 2, with no writeback
- ALUWB: regDst=1, memToReg=0, regWrite=1, retired=1. Next state FETCH.
- BRANCH: aluSrcA=1, aluSrcB=0, SUB, pcSrc=1, retired=1. Next state FETCH.
  - pcEn=zero for beq, pcEn=~zero for bne.
- ADDIEX: aluSrcA=1, aluSrcB=2, ADD. ADDIWB: regDst=0, memToReg=0, regWrite=1, retired=1. Next state FETCH.
- JUMP: pcSrc=2, pcEn=1, retired=1. Next state FETCH.
- FAULT: all enables and requests are 0. Terminal until reset. fault=1 and faultCause hold their values.
- Memory request rule: memRead/memWrite stay high and iOrD stays stable every cycle until memReady=1 is sampled. memReady outside FETCH, MEMRD and MEMWR is ignored.
- Wait counter:
  - Clears on entry to any memory state and on every memReady=1.
  - Increments each cycle the FSM is in a memory state with memReady=0.
  - If MEM_TIMEOUT>0 and the counter equals MEM_TIMEOUT-1 with memReady=0, the next state is FAULT with cause 3.
  - memReady=1 in the same cycle as that condition wins: the access completes normally.
- Latency with memReady tied to 1: lw 5 cycles, sw 4, R-type 4, addi 4, beq/bne 3, j 3. Each added wait cycle adds 1.

Test Plan:
- resetN=0 for 2 cycles, then 1, memReady=1 -> cycle after release: state=0, memRead=1, iOrD=0, pcEn=1, irWrite=1. No fault.
- opcode 0x23 with memReady=1 -> states 0,1,2,3,4. regWrite=1 and memToReg=1 only in state 4. retired pulses once. Total 5 cycles.
- opcode 0x00 with funct 0x22 -> EXEC gives aluControl=1. ALUWB gives regDst=1, regWrite=1. Repeat with funct 0x3F -> FAULT, faultCause=2, regWrite never asserted.
- opcode 0x04, zero=0, then zero=1 -> BRANCH pcEn=0, then pcEn=1 with pcSrc=1. Opcode 0x05 with ENABLE_BNE=0 -> faultCause=1.
- MEM_TIMEOUT=4, MEMRD with memReady held low -> memRead=1 for 4 cycles, then state=15, faultCause=3. Same run with memReady=1 on the 4th cycle -> MEMWB, no fault.
- Reset asserted during MEMWR wait -> memWrite=0 and retired=0 on the reset cycle. State=0 after the reset edge. The fault flag clears if it was previously set.
